// File: rtl/figan_pkg.sv
// Shared definitions for the FI-GAN generator neuron sequencers:
// default widths, the sequencer state encoding and Q8.8 constants.
package figan_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int FRAC_BITS_DEF  = 8;
  localparam int N_IN_DEF       = 9;
  localparam int ACC_WIDTH_DEF  = 36;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_BIAS,
    ST_SAT,
    ST_OUT
  } state_t;

  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

endpackage

// File: rtl/fx_shift_sat.sv
// Arithmetic right shift of a wide signed accumulator followed by saturation
// to a narrower signed result, with a flag raised whenever clipping occurred.
module fx_shift_sat #(
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8
) (
  input  logic signed [IN_WIDTH-1:0]  i_acc,
  output logic        [OUT_WIDTH-1:0] o_data,
  output logic                        o_sat
);

  logic signed [IN_WIDTH-1:0]      w_shifted;
  logic        [IN_WIDTH-OUT_WIDTH:0] w_top;
  logic                            w_ovf;

  assign w_shifted = i_acc >>> SHIFT;
  // The result fits only if every bit from the output sign bit upward agrees.
  assign w_top = w_shifted[IN_WIDTH-1:OUT_WIDTH-1];
  assign w_ovf = !((&w_top) || !(|w_top));

  always_comb begin
    o_sat  = w_ovf;
    o_data = w_shifted[OUT_WIDTH-1:0];
    if (w_ovf) begin
      if (w_top[IN_WIDTH-OUT_WIDTH]) begin
        o_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        o_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/out_neuron_seq.sv
// Output-layer neuron of the FI-GAN generator: one shared multiplier walks the
// weights, then bias is added and the Q8.8 result is saturated and handed off.
module out_neuron_seq
  import figan_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int N_IN       = N_IN_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN*DATA_WIDTH-1:0] x_bus,
  input  logic [N_IN*DATA_WIDTH-1:0] w_bus,
  input  logic [DATA_WIDTH-1:0]      bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_sat,
  output logic                       busy
);

  localparam int IDX_W  = $clog2(N_IN);
  localparam int PROD_W = 2 * DATA_WIDTH;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [N_IN*DATA_WIDTH-1:0]  r_x;
  logic [IDX_W-1:0]            r_idx;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0]       r_out_data;
  logic                        r_out_sat;
  logic                        r_out_valid;

  logic signed [DATA_WIDTH-1:0] w_x_arr [N_IN];
  logic signed [DATA_WIDTH-1:0] w_w_arr [N_IN];
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic                         w_last;
  logic [DATA_WIDTH-1:0]        w_sat_data;
  logic                         w_sat_flag;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
      assign w_x_arr[gi] = r_x[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_w_arr[gi] = w_bus[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_prod     = w_x_arr[r_idx] * w_w_arr[r_idx];
  assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  // Bias is Q8.8; align it with the Q16.16 products before adding.
  assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}},
                       bias, {FRAC_BITS{1'b0}}};
  assign w_last     = (r_idx == IDX_W'(N_IN - 1));

  fx_shift_sat #(
    .IN_WIDTH (ACC_WIDTH),
    .OUT_WIDTH(DATA_WIDTH),
    .SHIFT    (FRAC_BITS)
  ) u_shift_sat (
    .i_acc (r_acc),
    .o_data(w_sat_data),
    .o_sat (w_sat_flag)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_next = ST_MAC;
      ST_MAC:  if (w_last)    w_state_next = ST_BIAS;
      ST_BIAS:                w_state_next = ST_SAT;
      ST_SAT:                 w_state_next = ST_OUT;
      ST_OUT:  if (out_ready) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x   <= x_bus;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_idx <= r_idx + 1'b1;
        end
        ST_BIAS: r_acc <= r_acc + w_bias_ext;
        ST_SAT: begin
          r_out_data  <= w_sat_data;
          r_out_sat   <= w_sat_flag;
          r_out_valid <= 1'b1;
        end
        ST_OUT: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_out_neuron_seq.sv
// Directed bench for out_neuron_seq: a vector table with hand-computed
// results plus sequences for backpressure and mid-operation reset.
module tb_out_neuron_seq;

  localparam int DW  = 16;
  localparam int NI  = 9;
  localparam int LAT = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [NI*DW-1:0] x_bus;
  logic [NI*DW-1:0] w_bus;
  logic [DW-1:0]  bias;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_sat;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string          name;
    logic [NI*DW-1:0] x;
    logic [NI*DW-1:0] w;
    logic [DW-1:0]  b;
    logic [DW-1:0]  exp_data;
    logic           exp_sat;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  out_neuron_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_bus    (x_bus),
    .w_bus    (w_bus),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector and return once it has been accepted.
  task automatic send(input logic [NI*DW-1:0] x, input logic [NI*DW-1:0] w, input logic [DW-1:0] b);
    int n = 0;
    w_bus = w;
    bias  = b;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("in_ready_before_send", {31'b0, in_ready}, 32'd1);
    x_bus    = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    check({name, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.x, v.w, v.b);
    wait_out(lat);
    check({v.name, "_latency"}, lat, LAT);
    check({v.name, "_data"}, {16'b0, out_data}, {16'b0, v.exp_data});
    check({v.name, "_sat"}, {31'b0, out_sat}, {31'b0, v.exp_sat});
    $display("vec %s: data=0x%04h sat=%0d latency=%0d", v.name, out_data, out_sat, lat);
    consume(v.name);
  endtask

  initial begin
    logic [NI*DW-1:0] ramp;
    logic [DW-1:0]    held;
    int               lat;

    ramp = '0;
    for (int i = 0; i < NI; i++) ramp[i*DW +: DW] = 16'(i * 256);

    vecs[0] = '{"ones",      {NI{16'h0100}}, {NI{16'h0100}}, 16'h0000, 16'h0900, 1'b0};
    vecs[1] = '{"bias_only", {NI{16'h0000}}, {NI{16'h1234}}, 16'h0080, 16'h0080, 1'b0};
    vecs[2] = '{"sat_pos",   {NI{16'h7FFF}}, {NI{16'h7FFF}}, 16'h0000, 16'h7FFF, 1'b1};
    vecs[3] = '{"sat_neg",   {NI{16'h7FFF}}, {NI{16'h8001}}, 16'h0000, 16'h8000, 1'b1};
    vecs[4] = '{"floor_neg", {{8{16'h0}}, 16'hFFFF}, {{8{16'h0}}, 16'h0080}, 16'h0000, 16'hFFFF, 1'b0};
    vecs[5] = '{"neg_bias",  {{8{16'h0}}, 16'h0200}, {{8{16'h0}}, 16'hFF00}, 16'h0100, 16'hFF00, 1'b0};
    vecs[6] = '{"ramp",      ramp, {NI{16'h0100}}, 16'h0000, 16'h2400, 1'b0};
    vecs[7] = '{"edge_max",  {{8{16'h0}}, 16'h7FFF}, {{8{16'h0}}, 16'h0100}, 16'h0001, 16'h7FFF, 1'b1};
    vecs[8] = '{"edge_min",  {{8{16'h0}}, 16'h8000}, {{8{16'h0}}, 16'h0100}, 16'h0000, 16'h8000, 1'b0};
    vecs[9] = '{"below_min", {{8{16'h0}}, 16'h8000}, {{8{16'h0}}, 16'h0100}, 16'hFFFF, 16'h8000, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_bus = '0; w_bus = '0; bias = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  {16'b0, out_data},  32'd0);
    check("rst_out_sat",   {31'b0, out_sat},   32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure: result held, in_valid ignored while not in IDLE.
    send(vecs[0].x, vecs[0].w, vecs[0].b);
    wait_out(lat);
    check("bp_latency", lat, LAT);
    held = out_data;
    check("bp_data", {16'b0, held}, 32'h0900);
    x_bus = {NI{16'h0500}};
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      tick();
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_data",  {16'b0, out_data},  {16'b0, held});
      check("bp_in_ready",   {31'b0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    $display("seq backpressure: held data=0x%04h for 5 cycles", held);
    consume("bp");
    tick();
    check("bp_no_latch_busy", {31'b0, busy}, 32'd0);
    check("bp_no_latch_valid", {31'b0, out_valid}, 32'd0);
    send({NI{16'h0200}}, {NI{16'h0100}}, 16'h0000);
    wait_out(lat);
    check("bp_second_latency", lat, LAT);
    check("bp_second_data", {16'b0, out_data}, 32'h1200);
    $display("seq backpressure second vector: data=0x%04h", out_data);
    consume("bp2");

    // Reset asserted during the fourth MAC cycle.
    send(vecs[0].x, vecs[0].w, vecs[0].b);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy",      {31'b0, busy},      32'd0);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_data",  {16'b0, out_data},  32'd0);
    check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
    $display("seq mid-MAC reset: busy=%0d out_valid=%0d", busy, out_valid);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
